// File: rtl/screen_pkg.sv
// Shared screen-side definitions: the cell drawing FSM encoding, board and
// glyph geometry, and the system-level state used by the top-level FSM that
// sequences scan and cell_draw phases.
package screen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE,
        REARM
    } cell_draw_state_t;

    typedef enum logic [1:0] {
        SYS_IDLE,
        SYS_SCAN,
        SYS_CELL_DRAW
    } sys_state_t;

    localparam int BOARD_DIM = 9;
    localparam int GLYPH_PX  = 8;

endpackage

// File: rtl/cell_draw_engine_glyph_rom.sv
// digit_glyph_rom: combinational 8x8 digit font.
// Ports:
//   digit [3:0] : digit to render; 0 and 10..15 produce an empty row
//   row   [2:0] : glyph row, 0 = top
//   bits  [7:0] : pixel row, MSB = leftmost pixel
module digit_glyph_rom (
    input  logic [3:0] digit,
    input  logic [2:0] row,
    output logic [7:0] bits
);

    // Each glyph packs its eight rows top-to-bottom, top row in the MSB byte.
    localparam logic [63:0] GLYPH_1 = 64'h1838_1818_1818_7E00;
    localparam logic [63:0] GLYPH_2 = 64'h3C66_060C_3060_7E00;
    localparam logic [63:0] GLYPH_3 = 64'h3C66_061C_0666_3C00;
    localparam logic [63:0] GLYPH_4 = 64'h0C1C_3C6C_7E0C_0C00;
    localparam logic [63:0] GLYPH_5 = 64'h7E60_7C06_0666_3C00;
    localparam logic [63:0] GLYPH_6 = 64'h3C60_7C66_6666_3C00;
    localparam logic [63:0] GLYPH_7 = 64'h7E06_0C18_3030_3000;
    localparam logic [63:0] GLYPH_8 = 64'h3C66_663C_6666_3C00;
    localparam logic [63:0] GLYPH_9 = 64'h3C66_663E_060C_3800;

    logic [63:0] glyph;

    always_comb begin
        glyph = '0;
        case (digit)
            4'd1:    glyph = GLYPH_1;
            4'd2:    glyph = GLYPH_2;
            4'd3:    glyph = GLYPH_3;
            4'd4:    glyph = GLYPH_4;
            4'd5:    glyph = GLYPH_5;
            4'd6:    glyph = GLYPH_6;
            4'd7:    glyph = GLYPH_7;
            4'd8:    glyph = GLYPH_8;
            4'd9:    glyph = GLYPH_9;
            default: glyph = '0;
        endcase
    end

    // Row r lives at bit offset (7-r)*8, i.e. {~r, 3'b000}.
    assign bits = glyph[{~row, 3'b000} +: 8];

endmodule

// File: rtl/cell_draw_engine.sv
// cell_draw_engine: renders one board cell per scanner request into the
// framebuffer as a CELL_PX x CELL_PX square of background colour with a
// centred 8x8 digit glyph in the foreground colour.
//
// Optional build macro: CELL_HIGHLIGHT_EN adds cursor_row/cursor_col inputs
// and parameter HL_COLOR; the cell under the cursor gets HL_COLOR background.
//
// Ports:
//   clk, rst    : clock (rising edge), asynchronous active-high reset
//   start_cell  : request level; accepted once per rising request (REARM)
//   cell_row/col: board position 0..8; larger values set cell_err
//   cell_data   : 0 blank, 1..9 digit, 10..15 drawn as blank
//   fb_we/addr/data, fb_ready : pixel write handshake, held while stalled
//   busy        : high from acceptance through DONE
//   cell_done   : one-cycle completion pulse
//   cell_err    : sticky out-of-range position flag, cleared by rst only
module cell_draw_engine
    import screen_pkg::*;
#(
    parameter int CELL_PX  = 16,
    parameter int BOARD_X0 = 0,
    parameter int BOARD_Y0 = 0,
    parameter int FB_W     = 160,
    parameter int ADDR_W   = 15,
    parameter int PIX_W    = 4,
    parameter logic [PIX_W-1:0] FG_COLOR = 4'hF,
    parameter logic [PIX_W-1:0] BG_COLOR = 4'h0
`ifdef CELL_HIGHLIGHT_EN
    ,
    parameter logic [PIX_W-1:0] HL_COLOR = 4'h3
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_cell,
    input  logic [3:0]        cell_row,
    input  logic [3:0]        cell_col,
    input  logic [3:0]        cell_data,
`ifdef CELL_HIGHLIGHT_EN
    input  logic [3:0]        cursor_row,
    input  logic [3:0]        cursor_col,
`endif
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]  fb_data,
    input  logic              fb_ready,
    output logic              busy,
    output logic              cell_done,
    output logic              cell_err
);

    localparam int CW  = $clog2(CELL_PX);
    localparam int AW2 = ADDR_W + 2;
    localparam logic [CW-1:0] OFS  = CW'((CELL_PX - GLYPH_PX) / 2);
    localparam logic [CW-1:0] CMAX = CW'(CELL_PX - 1);

    cell_draw_state_t state, state_next;

    logic [3:0]    row_q, col_q, data_q;
    logic [CW-1:0] cx, cy;

    logic          coord_bad, accept, step, last_px;
    logic [3:0]    src_row, src_col, src_data;
    logic [CW-1:0] nx, ny, rel_x, rel_y;
    logic [2:0]    gx, gy;
    logic          in_win, digit_ok;
    logic [7:0]    glyph_bits;
    logic [AW2-1:0] px_x, px_y, px_addr;
    logic [PIX_W-1:0] bg_color, px_color;

`ifdef CELL_HIGHLIGHT_EN
    logic hl_q, hl_src;
`endif

    assign coord_bad = (cell_row >= 4'(BOARD_DIM)) || (cell_col >= 4'(BOARD_DIM));
    assign last_px   = (cx == CMAX) && (cy == CMAX);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        cell_done  = 1'b0;
        accept     = 1'b0;
        step       = 1'b0;
        case (state)
            IDLE: begin
                if (start_cell) begin
                    if (coord_bad) begin
                        state_next = DONE;
                    end else begin
                        state_next = DRAW;
                        accept     = 1'b1;
                    end
                end
            end
            DRAW: begin
                // fb_we is high for the whole of DRAW, so fb_ready alone
                // marks a completed pixel.
                busy = 1'b1;
                if (fb_ready) begin
                    step = 1'b1;
                    if (last_px) state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                cell_done  = 1'b1;
                state_next = REARM;
            end
            REARM: begin
                if (!start_cell) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- next pixel to present ----------------
    // In IDLE the first pixel is derived straight from the request so that
    // fb_we/addr/data are valid the cycle after acceptance; afterwards the
    // latched cell and the advanced scan position are used.
    always_comb begin
        if (state == IDLE) begin
            src_row  = cell_row;
            src_col  = cell_col;
            src_data = cell_data;
            nx       = '0;
            ny       = '0;
        end else begin
            src_row  = row_q;
            src_col  = col_q;
            src_data = data_q;
            if (cx == CMAX) begin
                nx = '0;
                ny = cy + 1'b1;
            end else begin
                nx = cx + 1'b1;
                ny = cy;
            end
        end
    end

    assign px_x    = AW2'(BOARD_X0) + AW2'(src_col) * AW2'(CELL_PX) + AW2'(nx);
    assign px_y    = AW2'(BOARD_Y0) + AW2'(src_row) * AW2'(CELL_PX) + AW2'(ny);
    assign px_addr = px_y * AW2'(FB_W) + px_x;

    // Positions left of the window wrap to >= CELL_PX-OFS >= 8, so a single
    // unsigned compare per axis covers both window edges.
    assign rel_x    = nx - OFS;
    assign rel_y    = ny - OFS;
    assign gx       = 3'(rel_x);
    assign gy       = 3'(rel_y);
    assign in_win   = ({1'b0, rel_x} < (CW+1)'(GLYPH_PX)) &&
                      ({1'b0, rel_y} < (CW+1)'(GLYPH_PX));
    assign digit_ok = (src_data != 4'd0) && (src_data <= 4'(BOARD_DIM));

    digit_glyph_rom u_rom (
        .digit (src_data),
        .row   (gy),
        .bits  (glyph_bits)
    );

`ifdef CELL_HIGHLIGHT_EN
    assign hl_src   = (state == IDLE) ? ((cell_row == cursor_row) && (cell_col == cursor_col))
                                      : hl_q;
    assign bg_color = hl_src ? HL_COLOR : BG_COLOR;
`else
    assign bg_color = BG_COLOR;
`endif

    assign px_color = (in_win && digit_ok && glyph_bits[3'd7 - gx]) ? FG_COLOR : bg_color;

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q    <= '0;
            col_q    <= '0;
            data_q   <= '0;
            cx       <= '0;
            cy       <= '0;
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_data  <= '0;
            cell_err <= 1'b0;
        end else begin
            if ((state == IDLE) && start_cell && coord_bad) cell_err <= 1'b1;
            if (accept) begin
                row_q   <= cell_row;
                col_q   <= cell_col;
                data_q  <= cell_data;
                cx      <= '0;
                cy      <= '0;
                fb_we   <= 1'b1;
                fb_addr <= ADDR_W'(px_addr);
                fb_data <= px_color;
            end else if (step) begin
                if (last_px) begin
                    fb_we <= 1'b0;
                    cx    <= '0;
                    cy    <= '0;
                end else begin
                    cx      <= nx;
                    cy      <= ny;
                    fb_addr <= ADDR_W'(px_addr);
                    fb_data <= px_color;
                end
            end
        end
    end

`ifdef CELL_HIGHLIGHT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         hl_q <= 1'b0;
        else if (accept) hl_q <= hl_src;
    end
`endif

endmodule
